// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: 8x8-bit register file, host load port and a
// READ/EXEC/WB(/WBH) pipeline that accepts one instruction at a time.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for host load or instruction; done pulses here
// READ   | instruction latched; operands read at the outgoing edge
// EXEC   | ALU result, high byte and status latched at outgoing edge
// WB     | result written to R[rd]
// WBH    | multiply high byte written to R[rd+1]
module alu_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_en,
    input  logic [2:0] load_addr,
    input  logic [7:0] load_data,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] opcode,
    input  logic [2:0] rd,
    input  logic [2:0] rs,
    input  logic [2:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [3:0] sreg
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_ADDC = 4'd2;
    localparam logic [3:0] OP_SUBC = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_NAND = 4'd7;
    localparam logic [3:0] OP_LSL  = 4'd8;
    localparam logic [3:0] OP_LSR  = 4'd9;
    localparam logic [3:0] OP_ASL  = 4'd10;
    localparam logic [3:0] OP_ASR  = 4'd11;
    localparam logic [3:0] OP_ROL  = 4'd12;
    localparam logic [3:0] OP_ROR  = 4'd13;
    localparam logic [3:0] OP_MUL  = 4'd14;
    localparam logic [3:0] OP_CMP  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB,
        S_WBH
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  regs [8];
    logic [3:0]  op_q;
    logic [2:0]  rd_q;
    logic [2:0]  rs_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [7:0]  hi_q;

    logic        accept;
    logic        exec_en;
    logic        wb_lo;
    logic        wb_hi;
    logic        done_nxt;

    logic [7:0]  alu_res;
    logic [7:0]  alu_hi;
    logic        alu_c;
    logic        alu_v;
    logic [3:0]  alu_sreg;
    logic [15:0] prod;
    logic [8:0]  sum9;
    logic [8:0]  diff9;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        accept      = 1'b0;
        exec_en     = 1'b0;
        wb_lo       = 1'b0;
        wb_hi       = 1'b0;
        done_nxt    = 1'b0;
        case (state)
            S_IDLE: begin
                // a host load in the same cycle wins; the instruction waits
                instr_ready = !load_en && !reset;
                if (instr_valid && instr_ready) begin
                    accept    = 1'b1;
                    state_nxt = S_READ;
                end
            end
            S_READ: state_nxt = S_EXEC;
            S_EXEC: begin
                exec_en = 1'b1;
                if (op_q == OP_CMP) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_WB: begin
                wb_lo = 1'b1;
                if (op_q == OP_MUL) begin
                    state_nxt = S_WBH;
                end else begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            S_WBH: begin
                wb_hi     = 1'b1;
                state_nxt = S_IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // carry-in only participates for the with-carry variants
    assign sum9  = {1'b0, a_q} + {1'b0, b_q} + {8'd0, (op_q == OP_ADDC) & sreg[1]};
    assign diff9 = {1'b0, a_q} - {1'b0, b_q} - {8'd0, (op_q == OP_SUBC) & sreg[1]};
    assign prod  = {8'd0, a_q} * {8'd0, b_q};

    always_comb begin
        alu_res = 8'd0;
        alu_hi  = 8'd0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_ADD, OP_ADDC: begin
                alu_res = sum9[7:0];
                alu_c   = sum9[8];
                alu_v   = (a_q[7] == b_q[7]) && (sum9[7] != a_q[7]);
            end
            OP_SUB, OP_SUBC: begin
                alu_res = diff9[7:0];
                alu_c   = diff9[8];
                alu_v   = (a_q[7] != b_q[7]) && (diff9[7] != a_q[7]);
            end
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_NAND: alu_res = ~(a_q & b_q);
            OP_LSL, OP_ASL: begin
                alu_res = {a_q[6:0], 1'b0};
                alu_c   = a_q[7];
            end
            OP_LSR: begin
                alu_res = {1'b0, a_q[7:1]};
                alu_c   = a_q[0];
            end
            OP_ASR: begin
                alu_res = {a_q[7], a_q[7:1]};
                alu_c   = a_q[0];
            end
            OP_ROL:  alu_res = {a_q[6:0], a_q[7]};
            OP_ROR:  alu_res = {a_q[0], a_q[7:1]};
            OP_MUL: begin
                alu_res = prod[7:0];
                alu_hi  = prod[15:8];
            end
            default: alu_res = 8'd0;
        endcase
        if (op_q == OP_CMP) begin
            alu_sreg = {3'b000, a_q == b_q};
        end else if (op_q == OP_MUL) begin
            alu_sreg = {1'b0, prod[15], 1'b0, prod == 16'd0};
        end else begin
            alu_sreg = {alu_v, alu_res[7], alu_c, alu_res == 8'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 8'd0;
            end
            op_q   <= 4'd0;
            rd_q   <= 3'd0;
            rs_q   <= 3'd0;
            a_q    <= 8'd0;
            b_q    <= 8'd0;
            hi_q   <= 8'd0;
            result <= 8'd0;
            sreg   <= 4'd0;
            done   <= 1'b0;
        end else begin
            done <= done_nxt;
            if (load_en && (state == S_IDLE)) begin
                regs[load_addr] <= load_data;
            end
            if (accept) begin
                op_q <= opcode;
                rd_q <= rd;
                rs_q <= rs;
            end
            if (state == S_READ) begin
                a_q <= regs[rd_q];
                b_q <= regs[rs_q];
            end
            if (exec_en) begin
                sreg <= alu_sreg;
                if (op_q != OP_CMP) begin
                    result <= alu_res;
                    hi_q   <= alu_hi;
                end
            end
            if (wb_lo) begin
                regs[rd_q] <= result;
            end
            if (wb_hi) begin
                regs[rd_q + 3'd1] <= hi_q;
            end
        end
    end

    assign dbg_data = regs[dbg_addr];
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: an arithmetic reference model predicts
// each instruction's result, status, latency and register file at issue time.
`timescale 1ns/100ps
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_en;
    logic [2:0] load_addr;
    logic [7:0] load_data;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] opcode;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [3:0] sreg;

    alu_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .rd          (rd),
        .rs          (rs),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .sreg        (sreg)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          accept;
        int          lat;
        logic [7:0]  res;
        logic [3:0]  sr;
        logic [63:0] regs;
    } exp_t;

    exp_t sbq[$];

    logic [7:0] m_regs [8];
    logic [7:0] m_res;
    logic [3:0] m_sr;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'd0;
        m_res = 8'd0;
        m_sr  = 4'd0;
    endtask

    // Reference behaviour in plain integer arithmetic.
    task automatic mexec(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s,
                         output int lat);
        int a, b, c, sa, sb, t, st, r, hi, p;
        bit cf, vf;
        a  = int'(m_regs[d]);
        b  = int'(m_regs[s]);
        c  = int'(m_sr[1]);
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        cf = 0; vf = 0; hi = 0; p = 0; r = 0; t = 0; st = 0;
        lat = 3;
        case (op)
            4'd0:  begin t = a + b;     r = t % 256;         cf = (t > 255); st = sa + sb;     vf = (st > 127 || st < -128); end
            4'd1:  begin t = a - b;     r = (t + 256) % 256; cf = (t < 0);   st = sa - sb;     vf = (st > 127 || st < -128); end
            4'd2:  begin t = a + b + c; r = t % 256;         cf = (t > 255); st = sa + sb + c; vf = (st > 127 || st < -128); end
            4'd3:  begin t = a - b - c; r = (t + 256) % 256; cf = (t < 0);   st = sa - sb - c; vf = (st > 127 || st < -128); end
            4'd4:  r = a ^ b;
            4'd5:  r = a & b;
            4'd6:  r = a | b;
            4'd7:  r = 255 - (a & b);
            4'd8, 4'd10: begin r = (a * 2) % 256; cf = (a >= 128); end
            4'd9:  begin r = a / 2; cf = (a % 2 == 1); end
            4'd11: begin r = a / 2 + ((a >= 128) ? 128 : 0); cf = (a % 2 == 1); end
            4'd12: r = (a * 2) % 256 + a / 128;
            4'd13: r = a / 2 + (a % 2) * 128;
            4'd14: begin p = a * b; r = p % 256; hi = p / 256; lat = 4; end
            default: lat = 2;
        endcase
        if (op == 4'd15) begin
            m_sr = {3'b000, a == b};
        end else if (op == 4'd14) begin
            m_res = 8'(r);
            m_sr  = {1'b0, p >= 32768, 1'b0, p == 0};
            m_regs[d] = 8'(r);
            m_regs[(int'(d) + 1) % 8] = 8'(hi);
        end else begin
            m_res = 8'(r);
            m_sr  = {vf, r >= 128, cf, r == 0};
            m_regs[d] = 8'(r);
        end
    endtask

    task automatic push_exp(input int acc, input int lat);
        exp_t e;
        e.accept = acc;
        e.lat    = lat;
        e.res    = m_res;
        e.sr     = m_sr;
        for (int i = 0; i < 8; i++) e.regs[i*8 +: 8] = m_regs[i];
        sbq.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic do_load(input logic [2:0] addr, input logic [7:0] data);
        wait_idle();
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        @(posedge clk);
        #1 load_en = 1'b0;
        m_regs[addr] = data;
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s,
                         input bit track);
        int n = 0;
        int acc, lat;
        @(negedge clk);
        opcode      = op;
        rd          = d;
        rs          = s;
        instr_valid = 1'b1;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 0, 1);
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        acc = cyc;
        #1 instr_valid = 1'b0;
        if (track) begin
            mexec(op, d, s, lat);
            push_exp(acc, lat);
        end
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("latency", cyc - mon_e.accept, mon_e.lat + 1);
                chk("result", int'(result), int'(mon_e.res));
                chk("sreg", int'(sreg), int'(mon_e.sr));
                chk("busy_at_done", int'(busy), 0);
                for (int i = 0; i < 8; i++) begin
                    dbg_addr = 3'(i);
                    #0.5;
                    chk($sformatf("reg%0d", i), int'(dbg_data), int'(mon_e.regs[i*8 +: 8]));
                end
            end
        end
    end

    initial begin
        int acc, lat, n;
        reset       = 1'b1;
        load_en     = 1'b1;
        load_addr   = 3'd3;
        load_data   = 8'hA5;
        instr_valid = 1'b1;
        opcode      = 4'd0;
        rd          = 3'd0;
        rs          = 3'd0;
        dbg_addr    = 3'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("ready_in_reset", int'(instr_ready), 0);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        load_en     = 1'b0;
        instr_valid = 1'b0;
        chk("reset_result", int'(result), 0);
        chk("reset_sreg", int'(sreg), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);

        // signed overflow on ADD
        do_load(3'd1, 8'h7F);
        do_load(3'd2, 8'h01);
        issue(4'd0, 3'd1, 3'd2, 1);
        // carry chain through ADDC
        do_load(3'd3, 8'hFF);
        do_load(3'd4, 8'h01);
        do_load(3'd5, 8'h00);
        issue(4'd0, 3'd3, 3'd4, 1);
        issue(4'd2, 3'd5, 3'd5, 1);
        // multiply with rd=7 wrapping high byte into R0
        do_load(3'd7, 8'h10);
        do_load(3'd0, 8'h20);
        issue(4'd14, 3'd7, 3'd0, 1);
        // compare equal leaves registers and result alone
        do_load(3'd1, 8'h55);
        do_load(3'd2, 8'h55);
        issue(4'd15, 3'd1, 3'd2, 1);

        // load and instruction offered together: load first, accept next cycle
        wait_idle();
        load_en     = 1'b1;
        load_addr   = 3'd6;
        load_data   = 8'h3C;
        instr_valid = 1'b1;
        opcode      = 4'd0;
        rd          = 3'd6;
        rs          = 3'd6;
        #0.5;
        chk("ready_with_load", int'(instr_ready), 0);
        @(posedge clk);
        #1 load_en = 1'b0;
        m_regs[6] = 8'h3C;
        @(negedge clk);
        chk("ready_after_load", int'(instr_ready), 1);
        @(posedge clk);
        acc = cyc;
        #1 instr_valid = 1'b0;
        mexec(4'd0, 3'd6, 3'd6, lat);
        push_exp(acc, lat);

        // load offered while busy must be dropped
        issue(4'd1, 3'd2, 3'd6, 1);
        load_en   = 1'b1;
        load_addr = 3'd0;
        load_data = 8'hEE;
        @(posedge clk);
        #1 load_en = 1'b0;

        // reset during EXEC abandons the ADD
        do_load(3'd4, 8'h11);
        wait_idle();
        issue(4'd0, 3'd4, 3'd4, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        chk("rst_exec_busy", int'(busy), 0);
        chk("rst_exec_done", int'(done), 0);
        chk("rst_exec_result", int'(result), 0);
        chk("rst_exec_sreg", int'(sreg), 0);
        issue(4'd15, 3'd4, 3'd0, 1);

        // randomized mix, issued back-to-back where no load intervenes
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 9) < 3) begin
                do_load(3'($urandom_range(0, 7)), 8'($urandom));
            end
            issue(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1);
        end

        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain", sbq.size(), 0);
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
